// File: rtl/tri_inv_pkg.sv
// rtl/tri_inv_pkg.sv - shared element/row types and loader FSM states for the triangular inverter path
package tri_inv_pkg;

  localparam int WIDTH    = 64;
  localparam int DEF_SIZE = 16;

  typedef logic [2*WIDTH-1:0] cplx_t;
  typedef cplx_t [DEF_SIZE-1:0] row_t;

  typedef enum logic {
    LD_LOAD  = 1'b0,
    LD_SERVE = 1'b1
  } ld_state_e;

endpackage

// File: rtl/tri_row_loader_idx.sv
// rtl/tri_row_loader_idx.sv - lower-triangle (row, col) walker with last-element detection
module tri_row_loader_idx #(
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [AW-1:0] row_o,
  output logic [AW-1:0] col_o,
  output logic          last_o
);

  logic [AW-1:0] row_q;
  logic [AW-1:0] col_q;

  assign last_o = (row_q == AW'(SIZE - 1)) && (col_q == AW'(SIZE - 1));
  assign row_o  = row_q;
  assign col_o  = col_q;

  // Clear wins over advance so an abort never leaves a half-stepped position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (last_o) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == row_q) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_row_loader.sv
// rtl/tri_row_loader.sv - buffers a streamed lower-triangular complex matrix and serves rows to the inverter
// Optional zero-diagonal flag enabled by TRI_ROW_LOADER_DIAG_CHECK_EN.
module tri_row_loader #(
  parameter int SIZE  = tri_inv_pkg::DEF_SIZE,
  parameter int WIDTH = tri_inv_pkg::WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2*WIDTH-1:0]        elem_i,
  input  logic                      elem_valid_i,
  output logic                      elem_ready_o,
  input  logic [$clog2(SIZE)-1:0]   mat_row_addr_i,
  input  logic                      mat_row_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0]   mat_row_o,
  output logic [$clog2(SIZE)-1:0]   mat_row_addr_o,
  output logic                      mat_row_valid_o,
  output logic                      start_o,
  input  logic                      inv_done_i,
  input  logic                      flush_i,
  output logic                      loaded_o,
  output logic                      diag_err_o
);

  import tri_inv_pkg::*;

  localparam int AW = $clog2(SIZE);
  localparam int EW = 2 * WIDTH;

  ld_state_e     state_q, state_d;
  logic          ready_q, loaded_q, start_q, valid_q;
  logic [AW-1:0] addr_q;
  logic [EW-1:0] row_q [SIZE];
  logic [EW-1:0] buf_q [SIZE][SIZE];

  logic [AW-1:0] idx_row, idx_col;
  logic          idx_last, idx_clr;
  logic          xfer, rd_fire, done_fire;

  assign xfer      = elem_valid_i && ready_q && !flush_i;
  assign rd_fire   = (state_q == LD_SERVE) && mat_row_addr_valid_i && !flush_i;
  assign done_fire = (state_q == LD_SERVE) && inv_done_i;
  assign idx_clr   = flush_i || done_fire;

  tri_row_loader_idx #(.SIZE(SIZE), .AW(AW)) u_idx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (idx_clr),
    .adv_i  (xfer),
    .row_o  (idx_row),
    .col_o  (idx_col),
    .last_o (idx_last)
  );

  always_comb begin
    state_d = state_q;
    if (flush_i)
      state_d = LD_LOAD;
    else if (state_q == LD_LOAD) begin
      if (xfer && idx_last)
        state_d = LD_SERVE;
    end else if (inv_done_i)
      state_d = LD_LOAD;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= LD_LOAD;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      for (int j = 0; j < SIZE; j++)
        row_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == LD_LOAD);
      loaded_q <= (state_d == LD_SERVE);
      start_q  <= (state_q == LD_LOAD) && (state_d == LD_SERVE);
      valid_q  <= rd_fire;
      if (rd_fire) begin
        addr_q <= mat_row_addr_i;
        for (int j = 0; j < SIZE; j++)
          row_q[j] <= buf_q[mat_row_addr_i][j];
      end
    end
  end

  // Starting a row blanks its upper-triangle columns, so stale data from the
  // previous matrix never reaches the inverter.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      if (idx_col == '0)
        for (int j = 1; j < SIZE; j++)
          buf_q[idx_row][j] <= '0;
      buf_q[idx_row][idx_col] <= elem_i;
    end
  end

  always_comb begin
    mat_row_o = '0;
    for (int j = 0; j < SIZE; j++)
      mat_row_o[j*EW +: EW] = row_q[j];
  end

  assign elem_ready_o    = ready_q;
  assign loaded_o        = loaded_q;
  assign start_o         = start_q;
  assign mat_row_valid_o = valid_q;
  assign mat_row_addr_o  = addr_q;

`ifdef TRI_ROW_LOADER_DIAG_CHECK_EN
  logic diag_q;
  logic elem_is_zero;

  // Sign bits are ignored so that -0.0 counts as a zero pivot.
  assign elem_is_zero = (elem_i[WIDTH-2:0] == '0) && (elem_i[EW-2:WIDTH] == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      diag_q <= 1'b0;
    else if (idx_clr)
      diag_q <= 1'b0;
    else if (xfer && (idx_row == idx_col) && elem_is_zero)
      diag_q <= 1'b1;
  end

  assign diag_err_o = diag_q;
`else
  assign diag_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tri_row_loader.sv
// tb/tb_tri_row_loader.sv - randomized self-checking bench for tri_row_loader against a behavioural model
`timescale 1ns/1ps
module tb_tri_row_loader;

  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int EW    = 2 * WIDTH;
  localparam int AW    = 4;
  localparam int NELEM = SIZE * (SIZE + 1) / 2;

`ifdef TRI_ROW_LOADER_DIAG_CHECK_EN
  localparam bit DIAG_EN = 1'b1;
`else
  localparam bit DIAG_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [EW-1:0]        elem_i;
  logic                 elem_valid_i;
  logic                 elem_ready_o;
  logic [AW-1:0]        mat_row_addr_i;
  logic                 mat_row_addr_valid_i;
  logic [SIZE*EW-1:0]   mat_row_o;
  logic [AW-1:0]        mat_row_addr_o;
  logic                 mat_row_valid_o;
  logic                 start_o;
  logic                 inv_done_i;
  logic                 flush_i;
  logic                 loaded_o;
  logic                 diag_err_o;

  always #5 clk = ~clk;

  tri_row_loader #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .elem_i               (elem_i),
    .elem_valid_i         (elem_valid_i),
    .elem_ready_o         (elem_ready_o),
    .mat_row_addr_i       (mat_row_addr_i),
    .mat_row_addr_valid_i (mat_row_addr_valid_i),
    .mat_row_o            (mat_row_o),
    .mat_row_addr_o       (mat_row_addr_o),
    .mat_row_valid_o      (mat_row_valid_o),
    .start_o              (start_o),
    .inv_done_i           (inv_done_i),
    .flush_i              (flush_i),
    .loaded_o             (loaded_o),
    .diag_err_o           (diag_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dut_starts = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Element k of the row-major lower-triangle stream sits at (r, c).
  function automatic void tri_pos(input int k, output int r, output int c);
    r = 0;
    while ((r + 1) * (r + 2) / 2 <= k) r++;
    c = k - r * (r + 1) / 2;
  endfunction

  // Behavioural model: the matrix as a 2-D array plus a count of loaded elements.
  logic [EW-1:0] m_buf [SIZE][SIZE];
  bit            m_serving = 1'b0;
  int            m_count   = 0;
  bit            e_ready = 1'b0, e_loaded = 1'b0, e_start = 1'b0, e_valid = 1'b0, e_diag = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [EW-1:0] e_row [SIZE];

  always @(posedge clk or posedge rst) begin : model
    int r, c;
    if (rst) begin
      m_serving = 1'b0; m_count = 0;
      e_ready = 1'b0; e_loaded = 1'b0; e_start = 1'b0; e_valid = 1'b0; e_diag = 1'b0;
      e_addr = '0;
      for (int j = 0; j < SIZE; j++) e_row[j] = '0;
    end else begin
      if (flush_i) begin
        m_serving = 1'b0; m_count = 0; e_diag = 1'b0; e_start = 1'b0; e_valid = 1'b0;
      end else if (!m_serving) begin
        e_start = 1'b0; e_valid = 1'b0;
        if (elem_valid_i && e_ready) begin
          tri_pos(m_count, r, c);
          if (c == 0)
            for (int j = 0; j < SIZE; j++) m_buf[r][j] = '0;
          m_buf[r][c] = elem_i;
          if (DIAG_EN && r == c && elem_i[62:0] == 63'd0 && elem_i[126:64] == 63'd0)
            e_diag = 1'b1;
          m_count++;
          if (m_count == NELEM) begin
            m_serving = 1'b1; m_count = 0; e_start = 1'b1;
          end
        end
      end else begin
        e_start = 1'b0;
        e_valid = mat_row_addr_valid_i;
        if (mat_row_addr_valid_i) begin
          e_addr = mat_row_addr_i;
          for (int j = 0; j < SIZE; j++) e_row[j] = m_buf[mat_row_addr_i][j];
        end
        if (inv_done_i) begin
          m_serving = 1'b0; m_count = 0; e_diag = 1'b0;
        end
      end
      e_ready  = !m_serving;
      e_loaded = m_serving;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (start_o === 1'b1) dut_starts++;
      chk("elem_ready", elem_ready_o, e_ready);
      chk("loaded", loaded_o, e_loaded);
      chk("start", start_o, e_start);
      chk("row_valid", mat_row_valid_o, e_valid);
      chk("diag_err", diag_err_o, e_diag);
      if (e_valid || rst) begin
        chk("row_addr", mat_row_addr_o, e_addr);
        for (int j = 0; j < SIZE; j++)
          chk($sformatf("row_col%0d", j), mat_row_o[j*EW +: EW], e_row[j]);
      end
    end
  end

  task automatic idle_inputs();
    elem_valid_i = 1'b0;
    mat_row_addr_valid_i = 1'b0;
    inv_done_i = 1'b0;
    flush_i = 1'b0;
  endtask

  function automatic logic [EW-1:0] elem_val(input int mode, input int r, input int c);
    if (mode == 1)
      return {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    if (mode == 2 && r == 4 && c == 4)
      return {64'd0, 64'h8000_0000_0000_0000};
    return {64'd0, 64'(r * 16 + c + 1)};
  endfunction

  // Offers one element, with random idle gaps and random (ignored) read/done noise.
  task automatic send_elem(input logic [EW-1:0] v);
    int guard = 0;
    bit acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      mat_row_addr_valid_i = 1'($urandom_range(0, 1));
      mat_row_addr_i = AW'($urandom_range(0, SIZE - 1));
      inv_done_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        elem_valid_i = 1'b0;
      end else begin
        elem_i = v;
        elem_valid_i = 1'b1;
        acc = elem_ready_o;
      end
      guard++;
      if (!acc && guard > 100) begin
        n_checks++; n_fail++;
        $display("FAIL send_elem_timeout: ready never seen, got %b, expected 1", elem_ready_o);
        acc = 1'b1;
      end
    end
  endtask

  task automatic load_range(input int k0, input int k1, input int mode);
    int r, c;
    for (int k = k0; k < k1; k++) begin
      tri_pos(k, r, c);
      send_elem(elem_val(mode, r, c));
    end
  endtask

  task automatic finish_load();
    @(negedge clk);
    idle_inputs();
    chk("start_after_last", start_o, 1'b1);
    chk("loaded_after_last", loaded_o, 1'b1);
    chk("ready_after_last", elem_ready_o, 1'b0);
  endtask

  task automatic read_rows(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      mat_row_addr_i = AW'(a);
      mat_row_addr_valid_i = 1'b1;
    end
    @(negedge clk);
    mat_row_addr_valid_i = 1'b0;
  endtask

  task automatic done_pulse();
    @(negedge clk); inv_done_i = 1'b1;
    @(negedge clk); inv_done_i = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ready"}, elem_ready_o, 1'b0);
    chk({nm, "_valid"}, mat_row_valid_o, 1'b0);
    chk({nm, "_start"}, start_o, 1'b0);
    chk({nm, "_loaded"}, loaded_o, 1'b0);
    chk({nm, "_diag"}, diag_err_o, 1'b0);
    chk({nm, "_row_any"}, {127'd0, |mat_row_o}, '0);
    chk({nm, "_addr"}, mat_row_addr_o, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    idle_inputs();
    elem_i = '0;
    mat_row_addr_i = '0;
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", elem_ready_o, 1'b1);

    // Directed load with r*16+c+1, full readback.
    load_range(0, NELEM, 0);
    finish_load();
    chk("model_r15c15", m_buf[15][15], {64'd0, 64'd256});
    read_rows(0, SIZE - 1);
    read_rows(3, 3);
    chk("lit_row3_valid", mat_row_valid_o, 1'b1);
    chk("lit_row3_addr", mat_row_addr_o, 4'd3);
    chk("lit_row3_col2", mat_row_o[2*EW +: EW], {64'd0, 64'd51});
    chk("lit_row3_col3", mat_row_o[3*EW +: EW], {64'd0, 64'd52});
    chk("lit_row3_col5", mat_row_o[5*EW +: EW], '0);
    done_pulse();

    // Flush mid-load, then reload; no start may appear in between.
    s0 = dut_starts;
    load_range(0, 50, 1);
    @(negedge clk); idle_inputs(); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    load_range(0, NELEM, 1);
    chk("no_start_before_reload", dut_starts, s0);
    finish_load();
    read_rows(3, 3);

    // Read of row 5 together with done.
    @(negedge clk);
    mat_row_addr_i = 4'd5; mat_row_addr_valid_i = 1'b1; inv_done_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("rd_done_valid", mat_row_valid_o, 1'b1);
    chk("rd_done_addr", mat_row_addr_o, 4'd5);
    chk("rd_done_ready", elem_ready_o, 1'b1);

    // Flush drops a read issued in the same cycle.
    load_range(0, NELEM, 1);
    finish_load();
    @(negedge clk); mat_row_addr_i = 4'd9; mat_row_addr_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk); idle_inputs();
    chk("flush_drops_read", mat_row_valid_o, 1'b0);
    chk("flush_ready", elem_ready_o, 1'b1);

    // Randomized serve traffic.
    repeat (3) begin
      load_range(0, NELEM, 1);
      finish_load();
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        mat_row_addr_valid_i = ($urandom_range(0, 3) != 0);
        mat_row_addr_i = AW'($urandom_range(0, SIZE - 1));
        flush_i = ($urandom_range(0, 49) == 0);
      end
      @(negedge clk); idle_inputs();
      done_pulse();
    end

    // Zero diagonal at (4,4) as -0.0.
    load_range(0, 15, 2);
    @(negedge clk); idle_inputs();
    chk("diag_after_44", diag_err_o, DIAG_EN);
    load_range(15, NELEM, 2);
    finish_load();
    chk("diag_in_serve", diag_err_o, DIAG_EN);
    done_pulse();
    chk("diag_cleared", diag_err_o, 1'b0);

    // Reset mid-load.
    load_range(0, 70, 1);
    #3 rst = 1'b1;
    #1 check_all_zero("rst_midload");
    @(negedge clk); rst = 1'b0; idle_inputs();
    load_range(0, NELEM, 0);
    finish_load();
    read_rows(0, SIZE - 1);

    // Reset mid-read.
    @(negedge clk); mat_row_addr_i = 4'd7; mat_row_addr_valid_i = 1'b1;
    @(negedge clk); mat_row_addr_i = 4'd8;
    #2 rst = 1'b1;
    #1 check_all_zero("rst_midread");
    @(negedge clk); rst = 1'b0; idle_inputs();
    load_range(0, NELEM, 1);
    finish_load();
    read_rows(0, SIZE - 1);
    done_pulse();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_row_loader.md
TRI_ROW_LOADER -- requirements
Module: tri_row_loader

Interface
REQ-001 Parameter SIZE, default 16: matrix dimension in rows and columns.
REQ-002 Parameter WIDTH, default 64: width of one real or imaginary part (IEEE double bits).
REQ-003 clk_i  in  1  single clock, rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 elem_i  in  2*WIDTH  complex element {imag, real}, streamed row-major, lower triangle only.
REQ-006 elem_valid_i / elem_ready_o  in/out  1  element handshake; transfer when both are high on a rising edge.
REQ-007 mat_row_addr_i / mat_row_addr_valid_i  in  clog2(SIZE) / 1  row read request from the inverter.
REQ-008 mat_row_o  out  SIZE x 2*WIDTH  requested row; column j in slice j.
REQ-009 mat_row_addr_o / mat_row_valid_o  out  clog2(SIZE) / 1  echo of the served address, and data-valid.
REQ-010 start_o  out  1  one-cycle pulse telling the inverter a full matrix is ready.
REQ-011 inv_done_i  in  1  the inverter has finished with the current matrix.
REQ-012 flush_i  in  1  synchronous abort.
REQ-013 loaded_o  out  1  high while in SERVE.
REQ-014 diag_err_o  out  1  sticky zero-diagonal flag (DIAG_CHECK_EN only; tied 0 otherwise).

Function
REQ-015 FSM states: LOAD and SERVE; reset state is LOAD.
REQ-016 In LOAD, elem_ready_o is 1; in SERVE, elem_ready_o is 0.
REQ-017 Counters row r and col c start at (0,0). Each transfer writes buffer[r][c]. It then advances c, or, when c==r, sets c=0 and increments r.
REQ-018 Writing element c==0 of row r zeroes columns 1..SIZE-1 of row r in the same cycle, so the upper-triangle entries read as zero.
REQ-019 The transfer with (r,c)==(SIZE-1,SIZE-1) is the last of SIZE*(SIZE+1)/2 elements (136 at SIZE=16). The FSM enters SERVE on the next edge.
REQ-020 start_o pulses high for exactly the first cycle of SERVE.
REQ-021 Read latency is 1 cycle. When mat_row_addr_valid_i is high in SERVE at edge N:
- mat_row_o = buffer[addr] after edge N+1
- mat_row_addr_o = addr
- mat_row_valid_o = 1
REQ-022 Back-to-back reads are supported every cycle. mat_row_valid_o is 0 in any cycle following no request.
REQ-023 Read requests in LOAD are ignored: mat_row_valid_o stays 0.
REQ-024 inv_done_i in SERVE returns the FSM to LOAD and clears r, c and diag_err_o. A read requested in the same cycle is still served.
REQ-025 inv_done_i in LOAD is ignored.
REQ-026 flush_i in any state:
- next state LOAD, with r and c cleared
- mat_row_valid_o forced 0 on the next edge, so a pending read is dropped
- start_o suppressed
- flush has priority over every other event
REQ-027 Buffer contents are not cleared by flush or done; they are overwritten row by row per REQ-018.

Reset
REQ-028 While rst_i is high, all outputs are 0: elem_ready_o, mat_row_valid_o, start_o, loaded_o, diag_err_o, mat_row_o, mat_row_addr_o.
REQ-029 While rst_i is high, state is LOAD and r=c=0. elem_ready_o rises on the first edge after rst_i falls.
REQ-030 Buffer storage needs no reset value.

Configuration
REQ-031 Macro TRI_ROW_LOADER_DIAG_CHECK_EN.
- When defined: a transfer with c==r whose real and imag parts are both ±0.0 (bits [62:0] zero in each half) sets diag_err_o on the next edge. The flag holds until inv_done_i, flush_i or reset. Loading continues normally.
- When undefined: the checker is absent and diag_err_o is constant 0.

Structure
REQ-032 Shared package tri_inv_pkg holds:
- WIDTH and default SIZE
- typedef cplx_t (2*WIDTH packed {imag, real})
- typedef row_t (SIZE x cplx_t)
- the loader FSM state enum
REQ-033 One sub-module, tri_row_loader_idx: the (r,c) counter with last-element detection, reused for the inverter's column indexing.

Verification
REQ-034 Load 136 elements of value r*16+c+1 (real part), imag 0, then read rows 0..15 back-to-back. Each row must match, upper entries must be 0, and mat_row_addr_o must echo the address one cycle later.
REQ-035 Complete a load. start_o must be high exactly one cycle after the 136th transfer, with loaded_o=1 and elem_ready_o=0.
REQ-036 Flush after 50 elements, then reload 136 elements. No start_o may occur until the second load completes, and row 3 must hold the new data.
REQ-037 Issue a read of row 5 in SERVE with inv_done_i asserted in the same cycle. Row 5 must be returned valid, then elem_ready_o=1 on the following cycle.
REQ-038 With TRI_ROW_LOADER_DIAG_CHECK_EN defined, load element (4,4)=-0.0. diag_err_o must rise after that transfer, persist through SERVE and clear on inv_done_i. With the macro undefined it must stay 0.
REQ-039 Assert rst_i mid-load (element 70) and mid-read. All outputs must drop to 0 asynchronously, and a full reload must then succeed.
